line_fifo_arbiter: RTL and testbench
====================================

// Module: line_fifo_arbiter
// PURPOSE
//  Owns the shared 16-bit option-line FIFO between parser (fill) and solver (recirculate).
//  Grants the single write port per phase and sequences solver pops.
//  Tracks occupancy and flags an unsolvable board when a full pass yields no progress.
//  Drains the FIFO between boards. Sits between parser/solver and the FIFO IP in the top level.
// PARAMETERS
//  WIDTH   16   option-line word width (matches FIFO din/dout)
//  DEPTH   1024 FIFO entries; occupancy width OW = $clog2(DEPTH+1)
// PORTS
//  clk_50mhz    in   1      system clock
//  rst          in   1      synchronous, active-high reset
//  p_valid      in   1      parser has a line to write
//  p_data       in   WIDTH  parser line
//  p_ready      out  1      parser write accepted this cycle when p_valid&&p_ready
//  s_valid      in   1      solver has a line to put back
//  s_data       in   WIDTH  solver line
//  s_ready      out  1      solver write accepted when s_valid&&s_ready
//  rd_req       in   1      solver requests next line
//  rd_grant     out  1      pop issued this cycle; data valid on FIFO dout next cycle
//  parse_done   in   1      pulse: board fully parsed
//  solve_done   in   1      pulse: board solved
//  progress     in   1      pulse: solver resolved >=1 cell
//  fifo_din     out  WIDTH  to FIFO din
//  fifo_wr_en   out  1      to FIFO wr_en
//  fifo_rd_en   out  1      to FIFO rd_en
//  fifo_full    in   1      from FIFO
//  fifo_empty   in   1      from FIFO
//  phase        out  2      0 FILL, 1 SOLVE, 2 DRAIN
//  occupancy    out  OW     entries currently held
//  stalled      out  1      sticky: no progress over one full pass
// BEHAVIOUR
//  Reset: phase=FILL, occupancy=0, stalled=0, all ready/grant/enables 0, fifo_din=0.
//  All outputs registered-state-driven combinationally; zero-cycle accept (same-cycle wr_en).
//  FILL: p_ready=!fifo_full; s_ready=0; rd_grant=0. parse_done -> SOLVE, snapshot pass_len=occupancy.
//  SOLVE: s_ready=!fifo_full; p_ready=0; rd_grant=rd_req&&!fifo_empty.
//   solve_done -> DRAIN (wins over stall/progress in same cycle).
//  DRAIN: fifo_rd_en=!fifo_empty each cycle; all ready/grant=0; when fifo_empty && occupancy==0 -> FILL,
//   stalled cleared on that transition.
//  fifo_wr_en = accepted write; fifo_din = granted requester's data, else holds last value.
//  occupancy: +1 on write, -1 on pop, unchanged on simultaneous write+pop; never wraps (saturate 0/DEPTH).
//  Stall: pass_cnt counts pops in SOLVE; progress clears pass_cnt and reloads pass_len=occupancy.
//   pass_cnt==pass_len with pass_len!=0 and no progress that cycle -> stalled=1, phase -> DRAIN.
//  progress and pop in same cycle: pass_cnt reloads to 0 (progress wins).
//  parse_done outside FILL / solve_done outside SOLVE: ignored.
//  rst mid-phase: immediate return to reset state; FIFO IP must be reset alongside externally.
// CONFIGURATION
//  LINE_FIFO_STATS_EN defined: adds out ports wr_count[31:0], pop_count[31:0], pass_count[15:0]
//   (writes, pops, completed passes per board; cleared on rst and on DRAIN->FILL).
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  FILL: 5 p_valid writes -> 5 fifo_wr_en pulses, occupancy=5, s_valid ignored (s_ready=0).
//  SOLVE: rd_req held, solver writes each popped line back -> occupancy stays 5, rd_grant every cycle.
//  Stall: 5 pops+5 rewrites with progress=0 -> stalled=1 on 5th pop, phase=DRAIN, drains to occupancy=0, -> FILL.
//  progress pulse at pop 3 -> pass_cnt reset, no stall through pop 7; stall at pop 8.
//  fifo_full=1 in FILL -> p_ready=0, no wr_en; rd_req with fifo_empty=1 in SOLVE -> rd_grant=0.
//  solve_done and pass-end in same cycle -> DRAIN, stalled=0; rst mid-SOLVE -> all outputs reset next cycle.

Source files
------------

// File: rtl/line_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// line_fifo_arbiter
//
// Owns the shared option-line FIFO that sits between the parser and the
// solver. The board is processed in three phases:
//   FILL  - the parser writes option lines into the FIFO.
//   SOLVE - the solver pops lines and writes them back (recirculation).
//   DRAIN - the FIFO is emptied before the next board.
// The module arbitrates the single FIFO write port by phase, issues solver
// pops, and tracks how many entries the FIFO holds. It also sets `stalled`
// when one full pass over the FIFO gives no progress.
//
// Optional build macro: LINE_FIFO_STATS_EN
//   When defined, adds per-board statistics ports wr_count, pop_count and
//   pass_count. They are cleared on rst and on DRAIN->FILL.
//
// Ports
//   clk_50mhz   in   system clock
//   rst         in   synchronous, active-high reset
//   p_valid     in   parser has a line to write
//   p_data      in   parser line
//   p_ready     out  parser write accepted when p_valid && p_ready
//   s_valid     in   solver has a line to put back
//   s_data      in   solver line
//   s_ready     out  solver write accepted when s_valid && s_ready
//   rd_req      in   solver requests the next line
//   rd_grant    out  pop issued this cycle; FIFO dout is valid next cycle
//   parse_done  in   pulse: board fully parsed (only honoured in FILL)
//   solve_done  in   pulse: board solved (only honoured in SOLVE)
//   progress    in   pulse: solver resolved at least one cell
//   fifo_din    out  FIFO write data (holds the last written value)
//   fifo_wr_en  out  FIFO write enable
//   fifo_rd_en  out  FIFO read enable
//   fifo_full   in   FIFO full flag
//   fifo_empty  in   FIFO empty flag
//   phase       out  0 FILL, 1 SOLVE, 2 DRAIN
//   occupancy   out  number of entries the FIFO currently holds
//   stalled     out  sticky: a full pass completed with no progress
// -----------------------------------------------------------------------------
module line_fifo_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             p_valid,
  input  logic [WIDTH-1:0] p_data,
  output logic             p_ready,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  input  logic             rd_req,
  output logic             rd_grant,
  input  logic             parse_done,
  input  logic             solve_done,
  input  logic             progress,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic [1:0]       phase,
  output logic [OW-1:0]    occupancy,
`ifdef LINE_FIFO_STATS_EN
  output logic [31:0]      wr_count,
  output logic [31:0]      pop_count,
  output logic [15:0]      pass_count,
`endif
  output logic             stalled
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SOLVE = 2'd1,
    DRAIN = 2'd2
  } phase_e;

  localparam logic [OW-1:0] OCC_MAX = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);

  phase_e           phase_q, phase_d;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    pass_cnt;
  logic [OW-1:0]    pass_len;
  logic [WIDTH-1:0] din_q;
  logic             stalled_q;
  logic             stall_set;
  logic             drain_pop;
  logic             p_wr;
  logic             s_wr;
  logic             pass_hit;
  logic             drain_exit;

  // ---------------------------------------------------------------------------
  // Per-phase handshakes. These are combinational from the registered phase,
  // so a write is accepted in the same cycle it is offered. All of them are
  // forced low while rst is high.
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first. Without
  // the default, a path that skips an assignment would infer a latch.
  always_comb begin
    p_ready   = 1'b0;
    s_ready   = 1'b0;
    rd_grant  = 1'b0;
    drain_pop = 1'b0;
    if (!rst) begin
      case (phase_q)
        FILL:  p_ready = !fifo_full;
        SOLVE: begin
          s_ready  = !fifo_full;
          rd_grant = rd_req && !fifo_empty;
        end
        DRAIN:   drain_pop = !fifo_empty;
        default: ;
      endcase
    end
  end

  assign p_wr       = p_valid && p_ready;
  assign s_wr       = s_valid && s_ready;
  assign fifo_wr_en = p_wr || s_wr;
  assign fifo_rd_en = rd_grant || drain_pop;
  assign fifo_din   = p_wr ? p_data : (s_wr ? s_data : din_q);

  // The pop that makes pass_cnt equal to pass_len ends the pass.
  assign pass_hit   = rd_grant && (pass_len != '0) && ((pass_cnt + OCC_ONE) == pass_len);
  assign drain_exit = (phase_q == DRAIN) && fifo_empty && (occ_q == '0);

  // ---------------------------------------------------------------------------
  // Phase sequencing. If solve_done arrives in the same cycle as a stall, the
  // board counts as solved, so stalled is not set.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_d   = phase_q;
    stall_set = 1'b0;
    case (phase_q)
      FILL: if (parse_done) phase_d = SOLVE;
      SOLVE: begin
        if (solve_done) begin
          phase_d = DRAIN;
        end else if (pass_hit && !progress) begin
          phase_d   = DRAIN;
          stall_set = 1'b1;
        end
      end
      DRAIN:   if (drain_exit) phase_d = FILL;
      default: phase_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      phase_q   <= FILL;
      occ_q     <= '0;
      stalled_q <= 1'b0;
      din_q     <= '0;
      pass_cnt  <= '0;
      pass_len  <= '0;
    end else begin
      phase_q <= phase_d;

      if (fifo_wr_en) din_q <= fifo_din;

      // A write and a pop in the same cycle cancel out. The count saturates
      // at both ends, so a misbehaving FIFO cannot make it wrap.
      case ({fifo_wr_en, fifo_rd_en})
        2'b10:   if (occ_q != OCC_MAX) occ_q <= occ_q + OCC_ONE;
        2'b01:   if (occ_q != '0) occ_q <= occ_q - OCC_ONE;
        default: ;
      endcase

      if (stall_set) begin
        stalled_q <= 1'b1;
      end else if (drain_exit) begin
        stalled_q <= 1'b0;
      end

      // A pass is one full sweep over the current FIFO contents. Progress
      // starts a new pass sized to what is held now; it wins over a
      // simultaneous pop.
      if (phase_q == FILL && parse_done) begin
        pass_len <= occ_q;
        pass_cnt <= '0;
      end else if (phase_q == SOLVE) begin
        if (progress) begin
          pass_len <= occ_q;
          pass_cnt <= '0;
        end else if (rd_grant) begin
          pass_cnt <= pass_cnt + OCC_ONE;
        end
      end
    end
  end

  assign phase     = phase_q;
  assign occupancy = occ_q;
  assign stalled   = stalled_q;

`ifdef LINE_FIFO_STATS_EN
  // Per-board statistics. They restart with each new board.
  always_ff @(posedge clk_50mhz) begin
    if (rst || drain_exit) begin
      wr_count   <= '0;
      pop_count  <= '0;
      pass_count <= '0;
    end else begin
      if (fifo_wr_en) wr_count <= wr_count + 32'd1;
      if (fifo_rd_en) pop_count <= pop_count + 32'd1;
      if (phase_q == SOLVE && pass_hit) pass_count <= pass_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_line_fifo_arbiter
//
// Directed bench for line_fifo_arbiter. A small behavioural FIFO answers the
// DUT's wr_en/rd_en and drives full/empty. The full and empty flags can be
// forced for boundary cases. Every write the stimulus expects to be accepted
// pushes its data into a scoreboard queue. A negedge monitor pops that queue
// on each fifo_wr_en and compares fifo_din, and it also counts pops and grants.
// -----------------------------------------------------------------------------
module tb_line_fifo_arbiter;
  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int OW    = $clog2(DEPTH + 1);

  logic             clk_50mhz = 1'b0;
  logic             rst;
  logic             p_valid, s_valid, rd_req;
  logic [WIDTH-1:0] p_data, s_data;
  logic             parse_done, solve_done, progress;
  logic             p_ready, s_ready, rd_grant;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [1:0]       phase;
  logic [OW-1:0]    occupancy;
  logic             stalled;
`ifdef LINE_FIFO_STATS_EN
  logic [31:0]      wr_count, pop_count;
  logic [15:0]      pass_count;
`endif

  line_fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_50mhz  (clk_50mhz),
    .rst        (rst),
    .p_valid    (p_valid),
    .p_data     (p_data),
    .p_ready    (p_ready),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .rd_req     (rd_req),
    .rd_grant   (rd_grant),
    .parse_done (parse_done),
    .solve_done (solve_done),
    .progress   (progress),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .phase      (phase),
    .occupancy  (occupancy),
`ifdef LINE_FIFO_STATS_EN
    .wr_count   (wr_count),
    .pop_count  (pop_count),
    .pass_count (pass_count),
`endif
    .stalled    (stalled)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // ---------------------------------------------------------------------------
  // Behavioural FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] model_q[$];
  int               lvl = 0;
  bit               force_full = 1'b0;
  bit               force_empty = 1'b0;

  assign fifo_full  = force_full || (lvl >= DEPTH);
  assign fifo_empty = force_empty || (lvl == 0);

  always @(posedge clk_50mhz) begin
    if (rst) begin
      model_q.delete();
    end else begin
      if (fifo_rd_en && model_q.size() != 0) void'(model_q.pop_front());
      if (fifo_wr_en) model_q.push_back(fifo_din);
    end
    lvl <= model_q.size();
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  logic [WIDTH-1:0] exp_din[$];
  int wr_seen = 0;
  int rd_seen = 0;
  int grant_seen = 0;

  always @(negedge clk_50mhz) begin
    if (!rst) begin
      if (fifo_wr_en) begin
        wr_seen++;
        if (exp_din.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got din %0h, want no write", fifo_din);
        end else begin
          check("fifo_din", 32'(fifo_din), 32'(exp_din.pop_front()));
        end
      end
      if (fifo_rd_en) rd_seen++;
      if (rd_grant) grant_seen++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge, and
  // direct checks follow 1 time unit later.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic idle();
    p_valid    = 1'b0;
    s_valid    = 1'b0;
    rd_req     = 1'b0;
    parse_done = 1'b0;
    solve_done = 1'b0;
    progress   = 1'b0;
  endtask

  // The parser writes n lines. The solver offers a line every cycle, and that
  // line must be ignored.
  task automatic fill(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      tick(); idle();
      p_valid = 1'b1; p_data = base + 16'(i);
      s_valid = 1'b1; s_data = 16'hEE00 + 16'(i);
      exp_din.push_back(base + 16'(i));
      #1;
      check("fill_p_ready", 32'(p_ready), 1);
      check("fill_s_ready", 32'(s_ready), 0);
    end
    tick(); idle(); #1;
    check("fill_occupancy", 32'(occupancy), n);
  endtask

  task automatic go_solve();
    tick(); idle(); parse_done = 1'b1;
    tick(); idle(); #1;
    check("enter_solve", 32'(phase), 1);
  endtask

  // n pops with rd_req held. Each popped line is written back in the same
  // cycle. Optional progress/solve_done pulses go on given pops, and
  // parse_done on pop 2 must be ignored.
  task automatic solve_pops(input logic [15:0] base, input int n, input int prog_at, input int done_at);
    for (int k = 1; k <= n; k++) begin
      tick(); idle();
      rd_req = 1'b1;
      s_valid = 1'b1; s_data = base + 16'(k);
      exp_din.push_back(base + 16'(k));
      progress   = (k == prog_at);
      solve_done = (k == done_at);
      parse_done = (k == 2);
      #1;
      check("pop_grant", 32'(rd_grant), 1);
      check("pop_phase", 32'(phase), 1);
      check("pop_stalled", 32'(stalled), 0);
      check("pop_occupancy", 32'(occupancy), 5);
    end
    tick(); idle(); #1;
  endtask

  task automatic wait_phase(input logic [1:0] want, input int budget);
    int n = 0;
    while (phase !== want && n < budget) begin
      tick();
      n++;
    end
    check("wait_phase", 32'(phase), 32'(want));
  endtask

  // Entered on the first DRAIN cycle with 5 entries held.
  task automatic drain_to_fill();
    rd_seen = 0;
    check("drain_rd_en", 32'(fifo_rd_en), 1);
    check("drain_p_ready", 32'(p_ready), 0);
    check("drain_s_ready", 32'(s_ready), 0);
    wait_phase(2'd0, 40);
    check("drain_pops", rd_seen, 5);
    check("drain_occupancy", 32'(occupancy), 0);
    check("drain_stalled_cleared", 32'(stalled), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    p_data = '0; s_data = '0;
    rst = 1'b1;
    // Offer a write during reset: it must not be accepted.
    p_valid = 1'b1; p_data = 16'hABCD;
    tick(); tick(); #1;
    check("rst_phase", 32'(phase), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_stalled", 32'(stalled), 0);
    check("rst_p_ready", 32'(p_ready), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_din", 32'(fifo_din), 0);
    rst = 1'b0; idle();

    // FILL: 5 lines. The solver is ignored.
    wr_seen = 0;
    fill(16'h1000, 5);
    check("fill_wr_pulses", wr_seen, 5);
    check("din_holds", 32'(fifo_din), 32'h1004);

    // FIFO full in FILL: no accept, no write.
    tick(); idle(); force_full = 1'b1; p_valid = 1'b1; p_data = 16'h2222; #1;
    check("full_p_ready", 32'(p_ready), 0);
    check("full_wr_en", 32'(fifo_wr_en), 0);
    tick(); idle(); force_full = 1'b0; #1;
    check("full_occupancy", 32'(occupancy), 5);

    // solve_done outside SOLVE is ignored.
    tick(); idle(); solve_done = 1'b1;
    tick(); idle(); #1;
    check("solve_done_in_fill", 32'(phase), 0);

    go_solve();

    // Empty FIFO in SOLVE: no grant.
    tick(); idle(); force_empty = 1'b1; rd_req = 1'b1; #1;
    check("empty_grant", 32'(rd_grant), 0);
    check("empty_rd_en", 32'(fifo_rd_en), 0);
    tick(); idle(); force_empty = 1'b0; #1;

    // Stall: 5 pops with no progress.
    grant_seen = 0;
    solve_pops(16'h3000, 5, 0, 0);
    check("stall_grants", grant_seen, 5);
    check("stall_set", 32'(stalled), 1);
    check("stall_phase", 32'(phase), 2);
    drain_to_fill();

    // Progress on pop 3 restarts the pass, so the stall comes on pop 8.
    fill(16'h4000, 5);
    go_solve();
    solve_pops(16'h4100, 8, 3, 0);
    check("prog_stall_set", 32'(stalled), 1);
    check("prog_stall_phase", 32'(phase), 2);
    drain_to_fill();

    // solve_done on the same pop that ends the pass: DRAIN, no stall.
    fill(16'h5000, 5);
    go_solve();
    solve_pops(16'h5100, 5, 0, 5);
    check("done_phase", 32'(phase), 2);
    check("done_not_stalled", 32'(stalled), 0);
    drain_to_fill();

    // rst in the middle of SOLVE.
    fill(16'h6000, 5);
    go_solve();
    solve_pops(16'h6100, 2, 0, 0);
    tick(); idle(); rd_req = 1'b1; s_valid = 1'b1; s_data = 16'h6FFF; rst = 1'b1; #1;
    check("rst_mid_wr_en", 32'(fifo_wr_en), 0);
    tick(); #1;
    check("rst_mid_phase", 32'(phase), 0);
    check("rst_mid_occupancy", 32'(occupancy), 0);
    check("rst_mid_stalled", 32'(stalled), 0);
    check("rst_mid_grant", 32'(rd_grant), 0);
    check("rst_mid_rd_en", 32'(fifo_rd_en), 0);
    check("rst_mid_din", 32'(fifo_din), 0);
    tick(); rst = 1'b0; idle(); #1;
    check("post_rst_p_ready", 32'(p_ready), 1);

    tick(); tick(); #1;
    check("scoreboard_left", exp_din.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
